muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   EX-stage multiply/divide unit holding HI/LO for the 5-stage MIPS pipeline.
//   Responder side of the hazard-unit handshake: it consumes Start/MULDIVMode from
//   EX decode and returns Busy, which the stall logic ORs with Start.
//   Runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency.
//   Serves MTHI/MTLO writes and MFHI/MFLO reads.
// PARAMETERS
//   MULT_CYCLES  5   cycles Busy is held for MULT/MULTU (>=1)
//   DIV_CYCLES   10  cycles Busy is held for DIV/DIVU (>=1)
// PORTS
//   clk      in   1   system clock, rising edge
//   reset_n  in   1   asynchronous active-low reset
//   Start    in   1   EX holds MULT/MULTU/DIV/DIVU this cycle
//   Mode     in   4   MULDIVMode: 0 NOTHING, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   A        in   32  forwarded rs value
//   B        in   32  forwarded rt value
//   Req      in   1   exception/interrupt taken this cycle; EX instruction is squashed
//   HILOSel  in   1   1 = read HI, 0 = read LO
//   Busy     out  1   operation in flight
//   Out      out  32  HILOSel ? HI : LO, combinational from current registers
// BEHAVIOUR
//   Reset: HI=0, LO=0, Busy=0, counter=0, state IDLE; reset mid-operation discards the result.
//   FSM IDLE->RUN:
//     Edge where Start & !Req & !Busy & Mode in {1..4}.
//     Latches A, B and Mode; computes the result into shadow regs.
//     Loads counter with MULT_CYCLES or DIV_CYCLES per Mode.
//     Busy=1 from the next cycle.
//   RUN: counter decrements each edge.
//   RUN->IDLE: edge where counter==1; HI/LO take the shadow result on that same edge.
//     Busy=0 from the next cycle, so Busy is high for exactly N cycles.
//   Start while Busy: ignored. The hazard unit guarantees this never occurs; the bench asserts it.
//   Start with Req=1: no state change, HI/LO untouched.
//   MTHI/MTLO: HI<=A / LO<=A at the edge where Mode==5/6 & !Req & !Busy. No Busy.
//   Mode NOTHING, or Start=0 with Mode in 1..4: no effect.
//   Arithmetic:
//     MULT: {HI,LO} = signed 64-bit product.
//     MULTU: {HI,LO} = unsigned 64-bit product.
//     DIV: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
//     DIV of 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//     DIVU: unsigned quotient and remainder.
//     Divide by zero (B==0): HI/LO unchanged at completion; full DIV_CYCLES Busy still applies.
//   In-flight op with Req=1 during RUN: completes normally (default build), per MIPS imprecise HI/LO.
//   Out during RUN shows old HI/LO. Legal, because MF* is stalled while Busy|Start.
// CONFIGURATION
//   MULDIV_CANCEL_EN:
//     Defined: Req=1 in RUN returns to IDLE on that edge. Busy=0 next cycle; HI/LO keep
//       pre-operation values.
//     Undefined: Req is ignored in RUN and the op retires as above.
// TESTING
//   1. MULT A=3, B=0xFFFFFFFE, Start 1 cycle -> Busy high exactly 5 cycles; then
//      HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   2. MULTU A=B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
//   3. DIV A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      DIVU 7/0 -> HI/LO unchanged, Busy 10 cycles.
//   4. MTHI A=0x12345678, then MFHI read -> HILOSel=1 gives Out=0x12345678 next cycle.
//      MTLO with Req=1 -> LO unchanged.
//   5. Start DIV with Req=1 -> Busy stays 0, HI/LO unchanged.
//      Assert reset_n=0 at cycle 4 of a DIV -> Busy=0, HI=LO=0 immediately.
//   6. Req=1 at cycle 2 of MULT:
//      MULDIV_CANCEL_EN defined -> Busy=0 next cycle, HI/LO old.
//      Undefined -> result written after 5 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : EX-stage multiply/divide unit owning the HI/LO registers of a
//             5-stage MIPS pipeline. Runs MULT/MULTU/DIV/DIVU with a fixed
//             multi-cycle latency (Busy held for exactly N cycles) and serves
//             MTHI/MTLO writes and MFHI/MFLO reads.
//  Ports    : clk      - clock, rising edge
//             reset_n  - asynchronous active-low reset
//             Start    - EX holds MULT/MULTU/DIV/DIVU this cycle
//             Mode[3:0]- 0 NOTHING,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO
//             A[31:0]  - forwarded rs value
//             B[31:0]  - forwarded rt value
//             Req      - exception/interrupt taken; EX instruction squashed
//             HILOSel  - 1 selects HI on Out, 0 selects LO
//             Busy     - operation in flight
//             Out[31:0]- HILOSel ? HI : LO (combinational)
//  Config   : MULDIV_CANCEL_EN - when defined, Req during an operation aborts
//             it and HI/LO keep their pre-operation values.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [3:0]  Mode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  input  logic        HILOSel,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam logic [3:0] MODE_MULT  = 4'd1;
  localparam logic [3:0] MODE_MULTU = 4'd2;
  localparam logic [3:0] MODE_DIV   = 4'd3;
  localparam logic [3:0] MODE_DIVU  = 4'd4;
  localparam logic [3:0] MODE_MTHI  = 4'd5;
  localparam logic [3:0] MODE_MTLO  = 4'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        shi_q, shi_d, slo_q, slo_d;  // shadow result
  logic               swr_q, swr_d;                // shadow result valid (not div-by-zero)

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated on the launch cycle from the forwarded operands
  // ---------------------------------------------------------------------------
  logic        is_mul, is_md, is_sdiv;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_abs, b_abs, dvd, dvs, dvs_nz, q_u, r_u, q_s, r_s;
  logic [31:0] res_hi, res_lo;

  assign is_mul  = (Mode == MODE_MULT) || (Mode == MODE_MULTU);
  assign is_md   = is_mul || (Mode == MODE_DIV) || (Mode == MODE_DIVU);
  assign is_sdiv = (Mode == MODE_DIV);

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide is done on magnitudes with the signs fixed afterwards. This
  // also yields the architectural 0x80000000 / -1 result (LO=0x80000000, HI=0)
  // without a special case, since |0x80000000| is 2^31 as an unsigned value.
  assign a_abs  = A[31] ? (~A + 32'd1) : A;
  assign b_abs  = B[31] ? (~B + 32'd1) : B;
  assign dvd    = is_sdiv ? a_abs : A;
  assign dvs    = is_sdiv ? b_abs : B;
  // Divide by zero result is discarded; substitute 1 to keep the divider defined.
  assign dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q_u    = dvd / dvs_nz;
  assign r_u    = dvd % dvs_nz;
  assign q_s    = (A[31] ^ B[31]) ? (~q_u + 32'd1) : q_u;
  assign r_s    = A[31] ? (~r_u + 32'd1) : r_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (Mode)
      MODE_MULT:  {res_hi, res_lo} = prod_s;
      MODE_MULTU: {res_hi, res_lo} = prod_u;
      MODE_DIV:   begin res_hi = r_s; res_lo = q_s; end
      MODE_DIVU:  begin res_hi = r_u; res_lo = q_u; end
      default:    ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      shi_q   <= 32'd0;
      slo_q   <= 32'd0;
      swr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      swr_q   <= swr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    swr_d   = swr_q;
    case (state_q)
      S_IDLE: begin
        if (Start && !Req && is_md) begin
          state_d = S_RUN;
          cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          shi_d   = res_hi;
          slo_d   = res_lo;
          swr_d   = is_mul || (B != 32'd0);
        end else if (!Req && (Mode == MODE_MTHI)) begin
          hi_d = A;
        end else if (!Req && (Mode == MODE_MTLO)) begin
          lo_d = A;
        end
      end
      S_RUN: begin
`ifdef MULDIV_CANCEL_EN
        if (Req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else
`endif
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (swr_q) begin
            hi_d = shi_q;
            lo_d = slo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy = (state_q == S_RUN);
  assign Out  = HILOSel ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit: directed cases plus
//             randomized operations against a plain-arithmetic HI/LO model.
//             Honours MULDIV_CANCEL_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic [3:0]  Mode;
  logic [31:0] A, B;
  logic        Req;
  logic        HILOSel;
  logic        Busy;
  logic [31:0] Out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .Mode    (Mode),
    .A       (A),
    .B       (B),
    .Req     (Req),
    .HILOSel (HILOSel),
    .Busy    (Busy),
    .Out     (Out)
  );

  // The hazard unit never issues Start while Busy; the bench must not either.
  always @(posedge clk) begin
    if (reset_n) assert (!(Start && Busy)) else $error("Start issued while Busy");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_hilo(input string tag);
    HILOSel = 1'b1; #1;
    check({tag, "_hi"}, Out, m_hi);
    HILOSel = 1'b0; #1;
    check({tag, "_lo"}, Out, m_lo);
  endtask

  // Architectural result of a completed MULT/MULTU/DIV/DIVU.
  task automatic model_md(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mode)
      4'd1: begin sp = sa * sb; {m_hi, m_lo} = sp; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; end
      4'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  function automatic int op_cycles(input logic [3:0] mode);
    return (mode <= 4'd2) ? MULT_N : DIV_N;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue a multiply/divide for one cycle, measure the Busy window, then check HI/LO.
  task automatic do_md(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] b,
                       input bit req, input string tag);
    int n;
    @(negedge clk);
    check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
    Start = 1'b1; Mode = mode; A = a; B = b; Req = req;
    @(negedge clk);
    Start = 1'b0; Mode = 4'd0; Req = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    while (Busy && n < 200) begin
      n++;
      if (n == 1) check_hilo({tag, "_run_old"});
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, req ? 0 : op_cycles(mode));
    if (!req) model_md(mode, a, b);
    check_hilo(tag);
  endtask

  task automatic do_mt(input logic [3:0] mode, input logic [31:0] a, input bit req,
                       input string tag);
    @(negedge clk);
    Start = 1'b0; Mode = mode; A = a; Req = req;
    @(negedge clk);
    Mode = 4'd0; Req = 1'b0; A = $urandom;
    check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    if (!req) begin
      if (mode == 4'd5) m_hi = a;
      else              m_lo = a;
    end
    check_hilo(tag);
  endtask

  // Mode 1..4 without Start must do nothing.
  task automatic do_noop(input string tag);
    @(negedge clk);
    Start = 1'b0; Mode = 4'($urandom_range(1, 4)); A = $urandom; B = $urandom; Req = 1'b0;
    @(negedge clk);
    Mode = 4'd0;
    check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    check_hilo(tag);
  endtask

  // Req pulsed during the second Busy cycle of a MULT.
  task automatic do_req_mid();
    int n;
    @(negedge clk);
    Start = 1'b1; Mode = 4'd1; A = 32'd7; B = 32'hFFFF_FFF7; Req = 1'b0;
    @(negedge clk);
    Start = 1'b0; Mode = 4'd0;
    n = 0;
    while (Busy && n < 200) begin
      n++;
      Req = (n == 2);
      @(negedge clk);
    end
    Req = 1'b0;
`ifdef MULDIV_CANCEL_EN
    check("req_mid_busy_cycles", n, 2);
`else
    check("req_mid_busy_cycles", n, MULT_N);
    model_md(4'd1, 32'd7, 32'hFFFF_FFF7);
`endif
    check_hilo("req_mid");
  endtask

  // Reset asserted during the fourth Busy cycle of a DIV.
  task automatic do_reset_mid();
    int n;
    @(negedge clk);
    Start = 1'b1; Mode = 4'd3; A = 32'd1000; B = 32'd3; Req = 1'b0;
    @(negedge clk);
    Start = 1'b0; Mode = 4'd0;
    n = 1;
    while (Busy && n < 4) begin
      n++;
      @(negedge clk);
    end
    check("rst_mid_reached_cycle4", n, 4);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    check_hilo("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (DIV_N + 2) @(negedge clk);
    check("rst_mid_busy_after", {31'd0, Busy}, 32'd0);
    check_hilo("rst_mid_after");
  endtask

  initial begin
    logic [3:0] mode;
    int         sel;
    reset_n = 1'b0; Start = 1'b0; Mode = 4'd0; A = 32'd0; B = 32'd0; Req = 1'b0; HILOSel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check_hilo("reset");
    reset_n = 1'b1;

    do_md(4'd1, 32'd3, 32'hFFFF_FFFE, 1'b0, "mult_3xm2");
    do_md(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    do_md(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    do_md(4'd4, 32'd7, 32'd0, 1'b0, "divu_by0");
    do_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    do_md(4'd3, 32'd5, 32'd0, 1'b0, "div_by0");
    do_mt(4'd5, 32'h1234_5678, 1'b0, "mthi");
    do_mt(4'd6, 32'hAABB_CCDD, 1'b1, "mtlo_req");
    do_mt(4'd6, 32'h0BAD_F00D, 1'b0, "mtlo");
    do_md(4'd3, 32'd100, 32'd7, 1'b1, "div_start_req");
    do_noop("noop");
    do_req_mid();
    do_reset_mid();

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      if (sel <= 3) begin
        mode = 4'(sel + 1);
        do_md(mode, pick_operand(), pick_operand(), 1'b0, "rnd_md");
      end else if (sel <= 5) begin
        mode = 4'(sel + 1);
        do_mt(mode, $urandom, ($urandom_range(0, 7) == 0), "rnd_mt");
      end else if (sel == 6) begin
        do_noop("rnd_noop");
      end else begin
        mode = 4'($urandom_range(1, 4));
        do_md(mode, pick_operand(), pick_operand(), 1'b1, "rnd_md_req");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
